// File: rtl/mte_receiver.sv
// ---------------------------------------------------------------------------
// mte_receiver
//   Receives a cipher stream of alternating (cipher-data, cipher-MAC) bytes,
//   decrypts each pair with the key captured at frame start, checks the MAC
//   and hands the verified plaintext byte downstream over a valid/ready port.
//   A frame ends on a verified 8'h03 byte or after MAX_BYTES output bytes.
//
// Ports
//   clock, reset_n        : single clock, asynchronous active-low reset
//   key                   : cipher/MAC key, captured when a frame starts
//   in_valid/in_data      : cipher byte stream input
//   in_ready              : block accepts in_data this cycle
//   out_valid/out_ready   : output handshake
//   out_data              : verified plaintext byte (8'h00 on MAC failure)
//   mac_ok                : MAC result for the current out_data
//   frame_done            : one-cycle pulse at end of frame
//   frame_err             : sticky MAC-failure flag for the current/last frame
//   valid_key             : registered (key != 0)
// ---------------------------------------------------------------------------
module mte_receiver #(
    parameter int N         = 8,
    parameter int MAX_BYTES = 32
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic [N-1:0] key,
    input  logic         in_valid,
    input  logic [N-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] out_data,
    output logic         mac_ok,
    output logic         frame_done,
    output logic         frame_err,
    output logic         valid_key
);

    localparam int CW = $clog2(MAX_BYTES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_GET_DATA,
        S_GET_MAC,
        S_OUT,
        S_DONE
    } state_t;

    state_t         r_state;
    state_t         w_next;
    logic [N-1:0]   r_key;
    logic [N-1:0]   r_cdata;
    logic [N-1:0]   r_out_data;
    logic           r_mac_ok;
    logic           r_frame_err;
    logic           r_valid_key;
    logic [CW-1:0]  r_cnt;

    logic           w_in_xfer;
    logic           w_out_xfer;
    logic [N-1:0]   w_plain;
    logic [N-1:0]   w_mac_exp;
    logic           w_mac_ok;
    logic           w_last;

    // DEC(c) = ROL3(c) ^ k, the inverse of ENC(p) = ROR3(p ^ k)
    function automatic logic [N-1:0] f_dec(input logic [N-1:0] c, input logic [N-1:0] k);
        return {c[N-4:0], c[N-1:N-3]} ^ k;
    endfunction

    assign w_in_xfer  = in_valid && in_ready;
    assign w_out_xfer = out_valid && out_ready;
    assign w_plain    = f_dec(r_cdata, r_key);
    assign w_mac_exp  = (w_plain ^ r_key) + N'(8'h5A);
    assign w_mac_ok   = (f_dec(in_data, r_key) == w_mac_exp);
    // out_data equals the plaintext whenever mac_ok is set, so it doubles as p here
    assign w_last     = (r_mac_ok && (r_out_data == N'(8'h03))) ||
                        (r_cnt == CW'(MAX_BYTES - 1));

    // state register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_state <= S_IDLE;
        else          r_state <= w_next;
    end

    // next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     if (w_in_xfer)  w_next = S_GET_MAC;
            S_GET_DATA: if (w_in_xfer)  w_next = S_GET_MAC;
            S_GET_MAC:  if (w_in_xfer)  w_next = S_OUT;
            S_OUT:      if (w_out_xfer) w_next = w_last ? S_DONE : S_GET_DATA;
            S_DONE:                     w_next = S_IDLE;
            default:                    w_next = S_IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        frame_done = 1'b0;
        case (r_state)
            S_IDLE:     in_ready   = r_valid_key;
            S_GET_DATA: in_ready   = 1'b1;
            S_GET_MAC:  in_ready   = 1'b1;
            S_OUT:      out_valid  = 1'b1;
            S_DONE:     frame_done = 1'b1;
            default:    ;
        endcase
    end

    // datapath
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_key       <= '0;
            r_cdata     <= '0;
            r_out_data  <= '0;
            r_mac_ok    <= 1'b0;
            r_frame_err <= 1'b0;
            r_valid_key <= 1'b0;
            r_cnt       <= '0;
        end else begin
            r_valid_key <= (key != '0);
            case (r_state)
                S_IDLE: if (w_in_xfer) begin
                    r_key       <= key;
                    r_cdata     <= in_data;
                    r_frame_err <= 1'b0;
                    r_cnt       <= '0;
                end
                S_GET_DATA: if (w_in_xfer) r_cdata <= in_data;
                S_GET_MAC: if (w_in_xfer) begin
                    r_mac_ok   <= w_mac_ok;
                    r_out_data <= w_mac_ok ? w_plain : '0;
                    if (!w_mac_ok) r_frame_err <= 1'b1;
                end
                S_OUT: if (w_out_xfer) r_cnt <= r_cnt + CW'(1);
                default: ;
            endcase
        end
    end

    assign out_data  = r_out_data;
    assign mac_ok    = r_mac_ok;
    assign frame_err = r_frame_err;
    assign valid_key = r_valid_key;

endmodule

// File: tb/tb_mte_receiver.sv
module tb_mte_receiver;

    localparam int MAXB = 32;

    logic       clock = 1'b0;
    logic       reset_n;
    logic [7:0] key;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       mac_ok;
    logic       frame_done;
    logic       frame_err;
    logic       valid_key;

    mte_receiver #(.N(8), .MAX_BYTES(MAXB)) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .key        (key),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .mac_ok     (mac_ok),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .valid_key  (valid_key)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [7:0] d;
        logic       ok;
        logic       err;
        logic       last;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_key;
    int         m_cnt;
    logic       m_infr;
    logic       m_err;
    logic       m_vk;
    logic       exp_done;

    function automatic logic [7:0] dec(input logic [7:0] c, input logic [7:0] k);
        logic [7:0] r;
        r = (c << 3) | (c >> 5);   // rotate left by 3
        return r ^ k;
    endfunction

    always @(posedge clock or negedge reset_n)
        if (!reset_n) m_vk <= 1'b0;
        else          m_vk <= (key != 8'h00);

    // single compare process, sampling on the falling edge
    initial begin
        exp_done = 1'b0;
        forever begin
            @(negedge clock);
            if (!reset_n) begin
                exp_done = 1'b0;
            end else begin
                chk("frame_done", frame_done, exp_done);
                exp_done = 1'b0;
                chk("valid_key", valid_key, m_vk);
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out", 1, 0);
                    end else begin
                        chk("out_data", out_data, q[0].d);
                        chk("mac_ok", mac_ok, q[0].ok);
                        chk("frame_err", frame_err, q[0].err);
                        if (out_ready) begin
                            exp_done = q[0].last;
                            void'(q.pop_front());
                        end
                    end
                end
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic push_byte(input logic [7:0] b);
        int t;
        t = 0;
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && t < 200) begin
            @(negedge clock);
            t++;
        end
        if (t >= 200) chk("in_ready_timeout", 0, 1);
        @(posedge clock);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_pair(input logic [7:0] c, input logic [7:0] m);
        exp_t       e;
        logic [7:0] p;
        if (!m_infr) begin
            m_key  = key;
            m_cnt  = 0;
            m_err  = 1'b0;
            m_infr = 1'b1;
        end
        push_byte(c);
        push_byte(m);
        p      = dec(c, m_key);
        e.ok   = (dec(m, m_key) == 8'((p ^ m_key) + 8'h5A));
        e.d    = e.ok ? p : 8'h00;
        m_err  = m_err | !e.ok;
        e.err  = m_err;
        e.last = (e.ok && p == 8'h03) || (m_cnt + 1 == MAXB);
        m_cnt++;
        if (e.last) m_infr = 1'b0;
        q.push_back(e);
    endtask

    task automatic wait_done();
        logic found;
        found = 1'b0;
        for (int t = 0; t < 20 && !found; t++) begin
            @(negedge clock);
            if (frame_done) found = 1'b1;
        end
        chk("done_seen", found, 1);
    endtask

    initial begin
        reset_n = 1'b0; key = 8'h00; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        m_infr = 1'b0; m_cnt = 0; m_err = 1'b0; m_key = 8'h00;
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_mac_ok", mac_ok, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_valid_key", valid_key, 0);
        chk("rst_in_ready", in_ready, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;

        // zero key blocks intake; byte offered meanwhile is ignored
        in_valid = 1'b1; in_data = 8'hAF;
        repeat (3) begin
            @(negedge clock);
            chk("zk_in_ready", in_ready, 0);
            chk("zk_valid_key", valid_key, 0);
        end
        @(posedge clock); #1;
        in_valid = 1'b0; key = 8'h3C;
        @(negedge clock);
        chk("vk_lag", in_ready, 0);
        @(negedge clock);
        chk("vk_in_ready", in_ready, 1);

        // good pair, then EOF pair
        send_pair(8'hAF, 8'h7D);
        chk("p1_out_valid", out_valid, 1);
        chk("p1_out_data", out_data, 8'h41);
        chk("p1_mac_ok", mac_ok, 1);
        chk("p1_frame_err", frame_err, 0);
        send_pair(8'hE7, 8'hB4);
        chk("eof_out_data", out_data, 8'h03);
        chk("eof_mac_ok", mac_ok, 1);
        wait_done();
        @(negedge clock);
        chk("done_one_cycle", frame_done, 0);

        // bad MAC; a failed byte that would be 03 must not end the frame
        send_pair(8'hAF, 8'h7E);
        chk("bad_out_data", out_data, 8'h00);
        chk("bad_mac_ok", mac_ok, 0);
        chk("bad_frame_err", frame_err, 1);
        send_pair(8'hE7, 8'hB5);
        chk("bad03_out_data", out_data, 8'h00);
        send_pair(8'hE7, 8'hB4);
        chk("err_held", frame_err, 1);
        wait_done();
        @(negedge clock);
        chk("err_sticky_idle", frame_err, 1);

        // output stall with in_valid hammering
        out_ready = 1'b0;
        send_pair(8'hAF, 8'h7D);
        chk("new_frame_err_clr", frame_err, 0);
        repeat (5) begin
            in_valid = 1'b1; in_data = 8'hAA;
            @(negedge clock);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_out_valid", out_valid, 1);
            chk("stall_out_data", out_data, 8'h41);
            @(posedge clock); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        send_pair(8'hE7, 8'hB4);
        wait_done();

        // MAX_BYTES limit, with a mid-frame key change that must be ignored
        for (int i = 0; i < MAXB; i++) begin
            if (i == 10) key = 8'h55;
            if (i == 30) key = 8'h3C;
            send_pair(8'hAF, 8'h7D);
        end
        wait_done();
        send_pair(8'hAF, 8'h7D);
        chk("next_frame_data", out_data, 8'h41);
        send_pair(8'hE7, 8'hB4);
        wait_done();

        // reset mid-frame while holding an output
        out_ready = 1'b0;
        send_pair(8'hAF, 8'h7D);
        @(posedge clock); #1;
        q.delete();
        m_infr  = 1'b0;
        reset_n = 1'b0;
        #1;
        chk("mrst_out_valid", out_valid, 0);
        chk("mrst_out_data", out_data, 0);
        chk("mrst_mac_ok", mac_ok, 0);
        chk("mrst_frame_done", frame_done, 0);
        chk("mrst_valid_key", valid_key, 0);
        chk("mrst_in_ready", in_ready, 0);
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        out_ready = 1'b1;
        send_pair(8'hAF, 8'h7D);
        send_pair(8'hE7, 8'hB4);
        wait_done();

        repeat (4) @(negedge clock);
        chk("queue_drained", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
